// File: rtl/ram_2r1w_clr_if.sv
// Port bundle for ram_2r1w_clr: two read ports, one write port, flush request and busy status.
// The master drives addresses, write data and flush; the slave (the RAM) returns read data and busy.
interface ram_2r1w_clr_if #(
  parameter int INDEX = 4,
  parameter int WIDTH = 8
);
  logic [INDEX-1:0] addr0_i;
  logic [WIDTH-1:0] data0_o;
  logic [INDEX-1:0] addr1_i;
  logic [WIDTH-1:0] data1_o;
  logic [INDEX-1:0] addr0wr_i;
  logic [WIDTH-1:0] data0wr_i;
  logic             we0_i;
  logic             flush_i;
  logic             busy_o;

  modport master (
    output addr0_i, addr1_i, addr0wr_i, data0wr_i, we0_i, flush_i,
    input  data0_o, data1_o, busy_o
  );

  modport slave (
    input  addr0_i, addr1_i, addr0wr_i, data0wr_i, we0_i, flush_i,
    output data0_o, data1_o, busy_o
  );
endinterface

// File: rtl/ram_2r1w_clr.sv
// 2-read/1-write register-array RAM with write-first bypass and a one-entry-per-cycle clear engine.
// Reads are registered (1 cycle); while busy_o is high, writes are dropped and both reads return zero.
module ram_2r1w_clr #(
  parameter int DEPTH = 16,
  parameter int INDEX = 4,
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  ram_2r1w_clr_if.slave bus
);
  localparam logic [INDEX-1:0] LAST = INDEX'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [INDEX-1:0] clr_ptr, clr_ptr_nxt;
  logic [WIDTH-1:0] ram [DEPTH];
  logic [WIDTH-1:0] data0_q, data1_q;
  logic             wr_en;
  logic             byp0, byp1;

  // Flush wins over a write in the same cycle; out-of-range write addresses are discarded.
  assign wr_en = (state == IDLE) && !bus.flush_i && bus.we0_i && (bus.addr0wr_i <= LAST);
  assign byp0  = wr_en && (bus.addr0_i == bus.addr0wr_i);
  assign byp1  = wr_en && (bus.addr1_i == bus.addr0wr_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      IDLE: begin
        if (bus.flush_i) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        if (bus.flush_i) begin
          clr_ptr_nxt = '0;
        end else if (clr_ptr == LAST) begin
          state_nxt   = IDLE;
          clr_ptr_nxt = '0;
        end else begin
          clr_ptr_nxt = clr_ptr + INDEX'(1);
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase
  end

  // Storage is deliberately left out of reset; the clear engine zeroes it after release.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      ram[clr_ptr] <= '0;
    end else if (wr_en) begin
      ram[bus.addr0wr_i] <= bus.data0wr_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data0_q <= '0;
      data1_q <= '0;
    end else if (state == CLEAR) begin
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      data0_q <= byp0 ? bus.data0wr_i : ram[bus.addr0_i];
      data1_q <= byp1 ? bus.data0wr_i : ram[bus.addr1_i];
    end
  end

  assign bus.data0_o = data0_q;
  assign bus.data1_o = data1_q;
  assign bus.busy_o  = (state == CLEAR);
endmodule

// File: tb/tb_ram_2r1w_clr.sv
// Bench for ram_2r1w_clr: a DEPTH=16 and a DEPTH=12 instance driven from one cycle task;
// an abstract array model queues expected outputs per edge and a monitor pops and compares them.
module tb_ram_2r1w_clr;
  logic clk = 1'b0;
  logic rst16, rst12;
  always #5 clk = ~clk;

  ram_2r1w_clr_if #(.INDEX(4), .WIDTH(8)) bus16 ();
  ram_2r1w_clr_if #(.INDEX(4), .WIDTH(8)) bus12 ();

  ram_2r1w_clr #(.DEPTH(16), .INDEX(4), .WIDTH(8)) dut16 (.clk(clk), .reset(rst16), .bus(bus16.slave));
  ram_2r1w_clr #(.DEPTH(12), .INDEX(4), .WIDTH(8)) dut12 (.clk(clk), .reset(rst12), .bus(bus12.slave));

  typedef struct {
    int         cyc;
    int         inst;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  logic [3:0] a0 [2];
  logic [3:0] a1 [2];
  logic [3:0] wa [2];
  logic [7:0] wd [2];
  logic       we [2];
  logic       fl [2];
  logic [7:0] mem [2][16];
  int         rem [2];
  int         dep [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [7:0] out0(input int k);
    return (k == 0) ? bus16.data0_o : bus12.data0_o;
  endfunction
  function automatic logic [7:0] out1(input int k);
    return (k == 0) ? bus16.data1_o : bus12.data1_o;
  endfunction
  function automatic logic busy(input int k);
    return (k == 0) ? bus16.busy_o : bus12.busy_o;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      chk($sformatf("sb inst%0d cyc%0d data0", mon_e.inst, mon_e.cyc), out0(mon_e.inst), mon_e.d0);
      chk($sformatf("sb inst%0d cyc%0d data1", mon_e.inst, mon_e.cyc), out1(mon_e.inst), mon_e.d1);
      chk($sformatf("sb inst%0d cyc%0d busy", mon_e.inst, mon_e.cyc), {7'd0, busy(mon_e.inst)}, {7'd0, mon_e.busy});
    end
  end

  // The clear pointer of the 12-entry instance must stay inside the array.
  always @(negedge clk) begin
    if (rst12) chk("clr_ptr12 in range", {7'd0, (dut12.clr_ptr > 4'd11)}, 8'd0);
  end

  // Model view: a clear makes the whole array zero at once (its progress is unobservable),
  // busy lasts DEPTH edges after the last flush or reset, and writes apply only when not busy.
  task automatic tick();
    exp_t e;
    bus16.addr0_i = a0[0]; bus16.addr1_i = a1[0]; bus16.addr0wr_i = wa[0];
    bus16.data0wr_i = wd[0]; bus16.we0_i = we[0]; bus16.flush_i = fl[0];
    bus12.addr0_i = a0[1]; bus12.addr1_i = a1[1]; bus12.addr0wr_i = wa[1];
    bus12.data0wr_i = wd[1]; bus12.we0_i = we[1]; bus12.flush_i = fl[1];
    for (int k = 0; k < 2; k++) begin
      e.cyc  = cyc + 1;
      e.inst = k;
      if (((k == 0) ? rst16 : rst12) == 1'b0) begin
        e.d0 = 8'h00; e.d1 = 8'h00; e.busy = 1'b1;
        rem[k] = dep[k];
        for (int j = 0; j < 16; j++) mem[k][j] = 8'h00;
      end else begin
        if (rem[k] > 0) begin
          e.d0 = 8'h00; e.d1 = 8'h00;
        end else begin
          e.d0 = (we[k] && !fl[k] && a0[k] == wa[k]) ? wd[k] : mem[k][a0[k]];
          e.d1 = (we[k] && !fl[k] && a1[k] == wa[k]) ? wd[k] : mem[k][a1[k]];
          if (we[k] && !fl[k]) mem[k][wa[k]] = wd[k];
        end
        if (fl[k]) begin
          rem[k] = dep[k];
          for (int j = 0; j < 16; j++) mem[k][j] = 8'h00;
        end else if (rem[k] > 0) begin
          rem[k]--;
        end
        e.busy = (rem[k] > 0);
      end
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int k);
    a0[k] = 4'd0; a1[k] = 4'd0; wa[k] = 4'd0; wd[k] = 8'h00; we[k] = 1'b0; fl[k] = 1'b0;
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy(k) && n < 100);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    dep[0] = 16; dep[1] = 12;
    for (int k = 0; k < 2; k++) begin
      idle_inputs(k);
      rem[k] = dep[k];
      for (int j = 0; j < 16; j++) mem[k][j] = 8'h00;
    end
    rst16 = 1'b1; rst12 = 1'b1;
    #1;
    rst16 = 1'b0; rst12 = 1'b0;
    #1;
    chk("reset busy", {7'd0, bus16.busy_o}, 8'd1);
    chk("reset data0", bus16.data0_o, 8'h00);
    chk("reset data1", bus16.data1_o, 8'h00);
    @(posedge clk); #1;
    repeat (3) tick();

    // Release and clear; a write issued during the clear must vanish.
    rst16 = 1'b1;
    we[0] = 1'b1; wa[0] = 4'd3; wd[0] = 8'hAA;
    tick();
    we[0] = 1'b0;
    n = 1;
    while (bus16.busy_o && n < 100) begin
      tick();
      n++;
    end
    chk("clear edges after reset", 8'(n), 8'd16);
    for (int i = 0; i < 16; i++) begin
      a0[0] = 4'(i); a1[0] = 4'(15 - i);
      tick();
      if (i == 3) chk("addr3 after dropped write", bus16.data0_o, 8'h00);
    end

    // Basic write then read.
    we[0] = 1'b1; wa[0] = 4'd7; wd[0] = 8'h5A;
    tick();
    we[0] = 1'b0; a0[0] = 4'd7; a1[0] = 4'd0;
    tick();
    chk("read addr7", bus16.data0_o, 8'h5A);
    chk("read addr0", bus16.data1_o, 8'h00);

    // Dual bypass, then a plain read of the same entry.
    we[0] = 1'b1; wa[0] = 4'd9; wd[0] = 8'h3C; a0[0] = 4'd9; a1[0] = 4'd9;
    tick();
    chk("bypass port0", bus16.data0_o, 8'h3C);
    chk("bypass port1", bus16.data1_o, 8'h3C);
    wd[0] = 8'h11;
    tick();
    we[0] = 1'b0; wd[0] = 8'h3C;
    tick();
    chk("no-bypass port0", bus16.data0_o, 8'h11);
    chk("no-bypass port1", bus16.data1_o, 8'h11);

    // Fill, flush with a competing write, restart the flush on the 5th clear edge.
    for (int i = 0; i < 16; i++) begin
      we[0] = 1'b1; wa[0] = 4'(i); wd[0] = 8'(i + 8'h80);
      tick();
    end
    fl[0] = 1'b1; we[0] = 1'b1; wa[0] = 4'd2; wd[0] = 8'hFF;
    tick();
    we[0] = 1'b0;
    n = 0;
    do begin
      fl[0] = (n == 4);
      tick();
      n++;
    end while (bus16.busy_o && n < 100);
    fl[0] = 1'b0;
    chk("busy edges after restarted flush", 8'(n), 8'd21);
    for (int i = 0; i < 16; i++) begin
      a0[0] = 4'(i); a1[0] = 4'(i ^ 1);
      tick();
      if (i == 2) chk("addr2 after flush", bus16.data0_o, 8'h00);
    end

    // Async reset while outputs hold nonzero data.
    we[0] = 1'b1; wa[0] = 4'd5; wd[0] = 8'h66; a0[0] = 4'd5; a1[0] = 4'd5;
    tick();
    we[0] = 1'b0;
    @(negedge clk); #1;
    rst16 = 1'b0;
    #1;
    chk("async reset busy", {7'd0, bus16.busy_o}, 8'd1);
    chk("async reset data0", bus16.data0_o, 8'h00);
    chk("async reset data1", bus16.data1_o, 8'h00);
    tick();
    rst16 = 1'b1;
    count_busy(0, n);
    chk("clear edges after idle reset", 8'(n), 8'd16);

    // Async reset between clear edges 8 and 9.
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    repeat (8) tick();
    @(negedge clk); #1;
    rst16 = 1'b0;
    #1;
    chk("mid-clear reset busy", {7'd0, bus16.busy_o}, 8'd1);
    chk("mid-clear reset data0", bus16.data0_o, 8'h00);
    tick();
    tick();
    rst16 = 1'b1;
    count_busy(0, n);
    chk("clear edges after mid-clear reset", 8'(n), 8'd16);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      a0[0] = 4'($urandom_range(0, 15));
      a1[0] = 4'($urandom_range(0, 15));
      wa[0] = ($urandom_range(0, 3) == 0) ? a0[0] : 4'($urandom_range(0, 15));
      wd[0] = 8'($urandom);
      we[0] = 1'($urandom_range(0, 1));
      fl[0] = ($urandom_range(0, 49) == 0);
      tick();
    end
    idle_inputs(0);

    // Non-power-of-two depth.
    rst12 = 1'b1;
    count_busy(1, n);
    chk("clear edges depth12", 8'(n), 8'd12);
    we[1] = 1'b1; wa[1] = 4'd11; wd[1] = 8'hC7;
    tick();
    we[1] = 1'b0; a0[1] = 4'd11; a1[1] = 4'd10;
    tick();
    chk("depth12 addr11", bus12.data0_o, 8'hC7);
    chk("depth12 addr10", bus12.data1_o, 8'h00);

    tick();
    tick();
    @(negedge clk); #1;
    chk("scoreboard drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
